// File: rtl/tron_pkg.sv
// Shared constants for the light-cycle collision arbiter: FSM state codes,
// default coordinate widths and default playfield dimensions.
package tron_pkg;

    localparam int TRON_NUM_PLAYERS = 2;
    localparam int TRON_X_W         = 8;
    localparam int TRON_Y_W         = 7;
    localparam int TRON_FIELD_W     = 160;
    localparam int TRON_FIELD_H     = 120;

    // Judgement FSM: snapshot in IDLE, read/check each player, write survivors, commit.
    localparam int         ST_W    = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CHK  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

endpackage

// File: rtl/tron_headon_cmp.sv
// Pairwise head-on detector: a player collides when any other alive player
// shares its exact {x,y}. Purely combinational.
module tron_headon_cmp #(
    parameter int NUM_PLAYERS = 2,
    parameter int X_W         = 8,
    parameter int Y_W         = 7
) (
    input  logic [NUM_PLAYERS*X_W-1:0] x,
    input  logic [NUM_PLAYERS*Y_W-1:0] y,
    input  logic [NUM_PLAYERS-1:0]     alive,
    output logic [NUM_PLAYERS-1:0]     collide
);

    // Compare every ordered pair; both members of an equal pair get flagged.
    always_comb begin
        collide = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (i != j && alive[i] && alive[j] &&
                    x[i*X_W +: X_W] == x[j*X_W +: X_W] &&
                    y[i*Y_W +: Y_W] == y[j*Y_W +: Y_W]) begin
                    collide[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tron_collision_arbiter.sv
// Per-tick collision judge for NUM_PLAYERS light-cycles. Every player is
// judged against the same pre-tick trail image; survivors are written back
// only after all reads, so losses within a tick are simultaneous.
module tron_collision_arbiter
    import tron_pkg::*;
#(
    parameter int NUM_PLAYERS = TRON_NUM_PLAYERS,
    parameter int X_W         = TRON_X_W,
    parameter int Y_W         = TRON_Y_W,
    parameter int FIELD_W     = TRON_FIELD_W,
    parameter int FIELD_H     = TRON_FIELD_H,
    localparam int ADDR_W     = Y_W + X_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       tick,
    input  logic                       round_clr,
    input  logic [NUM_PLAYERS*X_W-1:0] p_x,
    input  logic [NUM_PLAYERS*Y_W-1:0] p_y,
    output logic [ADDR_W-1:0]          mem_raddr,
    input  logic                       mem_rdata,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_waddr,
    output logic [NUM_PLAYERS-1:0]     lost,
    output logic                       busy,
    output logic                       done,
    output logic                       game_over,
    output logic [NUM_PLAYERS-1:0]     winner,
    output logic                       tick_overrun,
    output logic                       dbg_rdata
);

    localparam int IDX_W = $clog2(NUM_PLAYERS);

    logic [ST_W-1:0]            state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_PLAYERS*X_W-1:0] snap_x_q, snap_x_d;
    logic [NUM_PLAYERS*Y_W-1:0] snap_y_q, snap_y_d;
    logic [NUM_PLAYERS-1:0]     pending_q, pending_d;
    logic [NUM_PLAYERS-1:0]     lost_q, lost_d;
    logic [NUM_PLAYERS-1:0]     winner_q, winner_d;
    logic                       game_over_q, game_over_d;
    logic                       tick_overrun_q, tick_overrun_d;
    logic                       dbg_rdata_q, dbg_rdata_d;

    logic [NUM_PLAYERS-1:0]     oob_in, oob_snap, headon;
    logic [NUM_PLAYERS-1:0]     lost_fin;
    logic [3:0]                 alive_cnt;
    logic [X_W-1:0]             cur_x;
    logic [Y_W-1:0]             cur_y;
    logic [ADDR_W-1:0]          cur_addr;
    logic                       cur_alive, cur_inb, last_idx;

    // Head-on check runs on the live inputs so its result is ready on the
    // same edge that captures them into the snapshot registers.
    tron_headon_cmp #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .X_W         (X_W),
        .Y_W         (Y_W)
    ) u_headon (
        .x       (p_x),
        .y       (p_y),
        .alive   (~lost_q),
        .collide (headon)
    );

    // Bounds flags for the incoming positions and for the held snapshot.
    always_comb begin
        oob_in   = '0;
        oob_snap = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            oob_in[k]   = (int'(p_x[k*X_W +: X_W]) >= FIELD_W) ||
                          (int'(p_y[k*Y_W +: Y_W]) >= FIELD_H);
            oob_snap[k] = (int'(snap_x_q[k*X_W +: X_W]) >= FIELD_W) ||
                          (int'(snap_y_q[k*Y_W +: Y_W]) >= FIELD_H);
        end
    end

    // Attributes of the player currently selected by idx.
    always_comb begin
        cur_x     = snap_x_q[idx_q*X_W +: X_W];
        cur_y     = snap_y_q[idx_q*Y_W +: Y_W];
        cur_addr  = {cur_y, cur_x};
        cur_alive = ~lost_q[idx_q];
        cur_inb   = ~oob_snap[idx_q];
        last_idx  = (idx_q == IDX_W'(NUM_PLAYERS - 1));
    end

    // Loss vector and survivor count as they will stand after this tick commits.
    always_comb begin
        lost_fin  = lost_q | pending_q;
        alive_cnt = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            alive_cnt = alive_cnt + {3'b000, ~lost_fin[k]};
        end
    end

    // FSM next-state, memory port drive and judgement bookkeeping.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        snap_x_d       = snap_x_q;
        snap_y_d       = snap_y_q;
        pending_d      = pending_q;
        lost_d         = lost_q;
        winner_d       = winner_q;
        game_over_d    = game_over_q;
        tick_overrun_d = tick_overrun_q;
        dbg_rdata_d    = dbg_rdata_q;
        mem_raddr      = '0;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        done           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && !game_over_q) begin
                    snap_x_d  = p_x;
                    snap_y_d  = p_y;
                    pending_d = oob_in | headon;
                    idx_d     = '0;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                mem_raddr = cur_inb ? cur_addr : '0;
                state_d   = ST_CHK;
            end
            ST_CHK: begin
                // Address held so the BRAM output stays tied to this player.
                mem_raddr   = cur_inb ? cur_addr : '0;
                dbg_rdata_d = mem_rdata;
                if (mem_rdata && cur_alive && cur_inb) begin
                    pending_d[idx_q] = 1'b1;
                end
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = ST_WR;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (cur_alive && !pending_q[idx_q] && cur_inb) begin
                    mem_we    = 1'b1;
                    mem_waddr = cur_addr;
                end
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                lost_d      = lost_fin;
                game_over_d = game_over_q || (alive_cnt <= 4'd1);
                winner_d    = (alive_cnt == 4'd1) ? ~lost_fin : '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        if (tick && state_q != ST_IDLE) begin
            tick_overrun_d = 1'b1;
        end

        // Round restart aborts any judgement in flight; the trail memory is left alone.
        if (round_clr) begin
            state_d        = ST_IDLE;
            idx_d          = '0;
            pending_d      = '0;
            lost_d         = '0;
            winner_d       = '0;
            game_over_d    = 1'b0;
            tick_overrun_d = 1'b0;
            mem_we         = 1'b0;
            done           = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            snap_x_q       <= '0;
            snap_y_q       <= '0;
            pending_q      <= '0;
            lost_q         <= '0;
            winner_q       <= '0;
            game_over_q    <= 1'b0;
            tick_overrun_q <= 1'b0;
            dbg_rdata_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            snap_x_q       <= snap_x_d;
            snap_y_q       <= snap_y_d;
            pending_q      <= pending_d;
            lost_q         <= lost_d;
            winner_q       <= winner_d;
            game_over_q    <= game_over_d;
            tick_overrun_q <= tick_overrun_d;
            dbg_rdata_q    <= dbg_rdata_d;
        end
    end

    assign lost         = lost_q;
    assign winner       = winner_q;
    assign game_over    = game_over_q;
    assign tick_overrun = tick_overrun_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tron_collision_arbiter.sv
// Self-checking bench for tron_collision_arbiter with four players: a
// tick-level behavioural model plus a per-cycle compare process, directed
// scenarios with literal expectations, then randomized play.
module tb_tron_collision_arbiter;

    localparam int N   = 4;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int FW  = 160;
    localparam int FH  = 120;
    localparam int AW  = XW + YW;
    localparam int LAT = 3 * N + 1;

    logic          clk = 1'b0;
    logic          resetn, tick, round_clr;
    logic [N*XW-1:0] p_x;
    logic [N*YW-1:0] p_y;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic          mem_rdata, mem_we;
    logic [N-1:0]  lost, winner;
    logic          busy, done, game_over, tick_overrun, dbg_rdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    tron_collision_arbiter #(
        .NUM_PLAYERS (N), .X_W (XW), .Y_W (YW), .FIELD_W (FW), .FIELD_H (FH)
    ) dut (
        .clk (clk), .resetn (resetn), .tick (tick), .round_clr (round_clr),
        .p_x (p_x), .p_y (p_y), .mem_raddr (mem_raddr), .mem_rdata (mem_rdata),
        .mem_we (mem_we), .mem_waddr (mem_waddr), .lost (lost), .busy (busy),
        .done (done), .game_over (game_over), .winner (winner),
        .tick_overrun (tick_overrun), .dbg_rdata (dbg_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- trail BRAM model (1-cycle read latency) ----------------
    bit            mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0, mem_clr = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [AW-1:0] wlog [$];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int a = 0; a < (1 << AW); a++) mem[a] <= 1'b0;
        end else begin
            if (pre_we) mem[pre_addr] <= 1'b1;
            if (mem_we && resetn) begin
                mem[mem_waddr] <= 1'b1;
                wlog.push_back(mem_waddr);
            end
        end
        mem_rdata <= mem[mem_raddr];
    end

    // ---------------- behavioural model ----------------
    // m_c counts cycles since the accepted tick (0 = idle); the whole tick's
    // outcome is worked out from the pre-tick image at acceptance.
    int            m_c;
    logic [N-1:0]  m_lost, m_next_lost, m_win;
    logic          m_go, m_ovr, m_dbg;
    logic [AW-1:0] m_raddr [N];
    logic [AW-1:0] m_waddr [N];
    logic          m_wr    [N];
    logic          m_rbit  [N];

    always @(posedge clk) begin
        int xs [N];
        int ys [N];
        logic [N-1:0] pend;
        int alive_n;
        if (!resetn) begin
            m_c = 0; m_lost = '0; m_win = '0; m_go = 0; m_ovr = 0; m_dbg = 0;
            m_next_lost = '0;
        end else begin
            if (m_c >= 2 && m_c <= 2 * N && (m_c % 2) == 0) m_dbg = m_rbit[(m_c - 2) / 2];
            if (round_clr) begin
                m_c = 0; m_lost = '0; m_win = '0; m_go = 0; m_ovr = 0;
            end else if (m_c != 0) begin
                if (tick) m_ovr = 1;
                if (m_c == LAT) begin
                    m_lost  = m_next_lost;
                    alive_n = 0;
                    for (int k = 0; k < N; k++) if (!m_lost[k]) alive_n++;
                    m_go  = (alive_n <= 1);
                    m_win = (alive_n == 1) ? ~m_lost : '0;
                    m_c   = 0;
                end else begin
                    m_c++;
                end
            end else if (tick && !m_go) begin
                pend = '0;
                for (int k = 0; k < N; k++) begin
                    xs[k] = int'(p_x[k*XW +: XW]);
                    ys[k] = int'(p_y[k*YW +: YW]);
                end
                for (int k = 0; k < N; k++) begin
                    logic oob;
                    oob = (xs[k] >= FW) || (ys[k] >= FH);
                    m_waddr[k] = AW'(ys[k] * 256 + xs[k]);
                    m_raddr[k] = oob ? '0 : m_waddr[k];
                    m_rbit[k]  = mem[m_raddr[k]];
                    if (oob) pend[k] = 1;
                    if (!m_lost[k] && !oob && mem[m_waddr[k]]) pend[k] = 1;
                    for (int j = 0; j < N; j++)
                        if (j != k && !m_lost[k] && !m_lost[j] && xs[j] == xs[k] && ys[j] == ys[k])
                            pend[k] = 1;
                end
                for (int k = 0; k < N; k++) m_wr[k] = !m_lost[k] && !pend[k];
                m_next_lost = m_lost | pend;
                m_c = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int k;
        logic exp_we;
        if (resetn) begin
            exp_we = 1'b0;
            k = m_c - (2 * N + 1);
            if (k >= 0 && k < N) exp_we = m_wr[k] && !round_clr;
            check("busy", busy, m_c != 0);
            check("done", done, (m_c == LAT) && !round_clr);
            check("mem_we", mem_we, exp_we);
            if (exp_we) check("mem_waddr", mem_waddr, m_waddr[k]);
            if (m_c >= 1 && m_c <= 2 * N) check("mem_raddr", mem_raddr, m_raddr[(m_c - 1) / 2]);
            check("lost", lost, m_lost);
            check("game_over", game_over, m_go);
            check("winner", winner, m_win);
            check("tick_overrun", tick_overrun, m_ovr);
            check("dbg_rdata", dbg_rdata, m_dbg);
        end
    end

    // ---------------- stimulus helpers (inputs change at posedge+2) ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_pos(input int k, input int x, input int y);
        p_x[k*XW +: XW] = XW'(x);
        p_y[k*YW +: YW] = YW'(y);
    endtask

    task automatic preload(input int x, input int y);
        pre_addr = {YW'(y), XW'(x)};
        pre_we   = 1'b1;
        step(1);
        pre_we   = 1'b0;
    endtask

    task automatic clr_round();
        round_clr = 1'b1;
        step(1);
        round_clr = 1'b0;
    endtask

    // Pulses tick, returns the cycle in which done was seen (-1 on timeout)
    // and the read address in cycle 1; leaves time at +3 of that cycle.
    task automatic run_tick(output int lat, output logic [AW-1:0] rd0);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        lat  = -1;
        rd0  = 'x;
        for (int c = 1; c <= 4 * LAT; c++) begin
            #1;
            if (c == 1) rd0 = mem_raddr;
            if (done) begin lat = c; break; end
            @(posedge clk); #2;
        end
        if (lat < 0) check("done timeout", 32'd0, 32'd1);
    endtask

    // Moves to +3 of the cycle after FIN, where the commit is visible.
    task automatic settle();
        step(1);
        #1;
    endtask

    int            lat;
    logic [AW-1:0] rd0;

    initial begin
        resetn = 1'b0; tick = 1'b0; round_clr = 1'b0; p_x = '0; p_y = '0;
        step(3);
        #1;
        check("reset busy", busy, 0);
        check("reset lost", lost, 0);
        check("reset mem_we", mem_we, 0);
        check("reset raddr", mem_raddr, 0);
        check("reset winner/go/ovr/dbg", {winner, game_over, tick_overrun, dbg_rdata}, 0);
        resetn = 1'b1;
        step(2);

        // Empty memory: everyone survives, writes in player order.
        set_pos(0, 10, 5); set_pos(1, 20, 5); set_pos(2, 30, 6); set_pos(3, 40, 7);
        wlog.delete();
        run_tick(lat, rd0);
        check("latency", lat, 13);
        settle();
        check("s1 lost", lost, 4'b0000);
        check("s1 model lost", m_lost, 4'b0000);
        check("s1 writes", wlog.size(), 4);
        if (wlog.size() >= 2) begin
            check("s1 write0", wlog[0], 15'd1290);
            check("s1 write1", wlog[1], 15'd1300);
        end

        // Three players hit preloaded trail: single winner P0.
        clr_round();
        preload(21, 5); preload(31, 6); preload(41, 7);
        set_pos(0, 11, 5); set_pos(1, 21, 5); set_pos(2, 31, 6); set_pos(3, 41, 7);
        run_tick(lat, rd0);
        settle();
        check("s2 lost", lost, 4'b1110);
        check("s2 game_over", game_over, 1);
        check("s2 winner", winner, 4'b0001);
        tick = 1'b1; step(1); tick = 1'b0; #1;
        check("tick after game_over ignored", busy, 0);
        check("no overrun when idle", tick_overrun, 0);

        // Head-on between P0 and P2.
        clr_round();
        set_pos(0, 30, 30); set_pos(1, 50, 50); set_pos(2, 30, 30); set_pos(3, 60, 60);
        wlog.delete();
        run_tick(lat, rd0);
        settle();
        check("s3 lost", lost, 4'b0101);
        check("s3 game_over", game_over, 0);
        check("s3 writes", wlog.size(), 2);
        for (int i = 0; i < wlog.size(); i++) check("s3 no head-on write", wlog[i] == 15'd7710, 0);

        // Overrun tick at cycle 3, then round_clr during P1's WR slot.
        set_pos(1, 51, 50); set_pos(3, 61, 60);
        tick = 1'b1; step(1); tick = 1'b0;   // cycle 1
        step(2);                             // cycle 3
        tick = 1'b1; step(1); tick = 1'b0;   // cycle 4
        #1;
        check("overrun flag", tick_overrun, 1);
        step(6);                             // cycle 10: WR of P1
        round_clr = 1'b1;
        #1;
        check("mem_we dropped", mem_we, 0);
        step(1);
        round_clr = 1'b0;
        #1;
        check("clr busy", busy, 0);
        check("clr lost", lost, 0);
        check("clr overrun", tick_overrun, 0);

        // Out-of-bounds on both axes; address 0 occupied; far corner is in bounds.
        preload(0, 0);
        set_pos(0, 160, 10); set_pos(1, 70, 70); set_pos(2, 80, 120); set_pos(3, 159, 119);
        run_tick(lat, rd0);
        check("oob raddr", rd0, 0);
        settle();
        check("s4 lost", lost, 4'b0101);
        check("s4 game_over", game_over, 0);

        // Every player hits trail: draw.
        clr_round();
        for (int k = 0; k < N; k++) preload(100 + k, 100);
        for (int k = 0; k < N; k++) set_pos(k, 100 + k, 100);
        run_tick(lat, rd0);
        settle();
        check("s5 lost", lost, 4'b1111);
        check("s5 game_over", game_over, 1);
        check("s5 winner", winner, 4'b0000);

        // Randomized play in a small corner straddling the field edges.
        for (int t = 0; t < 60; t++) begin
            if (m_go || ($urandom_range(0, 9) == 0)) begin
                for (int w = 0; w < 2 * LAT && busy; w++) step(1);
                if (!m_go) clr_round();
                mem_clr = 1'b1; round_clr = 1'b1;
                step(1);
                mem_clr = 1'b0; round_clr = 1'b0;
            end
            for (int k = 0; k < N; k++) set_pos(k, $urandom_range(154, 161), $urandom_range(114, 121));
            tick = 1'b1; step(1); tick = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                step($urandom_range(1, LAT));
                round_clr = 1'b1; step(1); round_clr = 1'b0;
            end
            step($urandom_range(2, LAT + 4));
        end
        step(LAT + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
